// File: rtl/feature_frame_builder_if.sv
// Stream-in / frame-out bundle for feature_frame_builder.
// The slave modport is the builder's view; master is the producer/consumer side.
// frame_silent exists only when FRAME_SILENCE_FLAG_EN is defined.
interface feature_frame_builder_if #(
  parameter int N_FEAT = 26,
  parameter int W      = 16
);
  logic signed [W-1:0] s_feat;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic signed [W-1:0] features [N_FEAT];
  logic                frame_valid;
  logic                frame_ready;
  logic                frame_err;
  logic [7:0]          err_cnt;
`ifdef FRAME_SILENCE_FLAG_EN
  logic                frame_silent;
`endif

  modport slave (
    input  s_feat, s_valid, s_last, frame_ready,
    output s_ready, features, frame_valid, frame_err,
`ifdef FRAME_SILENCE_FLAG_EN
    output frame_silent,
`endif
    output err_cnt
  );

  modport master (
    output s_feat, s_valid, s_last, frame_ready,
    input  s_ready, features, frame_valid, frame_err,
`ifdef FRAME_SILENCE_FLAG_EN
    input  frame_silent,
`endif
    input  err_cnt
  );
endinterface

// File: rtl/feature_frame_builder.sv
// Purpose: gathers a serial coefficient stream into double-buffered N_FEAT-wide frames; drops/counts malformed frames.
// Latency: last beat at edge E0 -> frame_valid and s_ready high in the cycle after E1 (one FULL cycle); N_FEAT+1 cycles/frame.
// Backpressure: s_ready drops while a complete frame waits for a held output slot; optional FRAME_SILENCE_FLAG_EN adds frame_silent.
module feature_frame_builder #(
  parameter int N_FEAT = 26,
  parameter int W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  feature_frame_builder_if.slave bus
);
  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  typedef enum logic [1:0] {FILL, FULL, DISCARD} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic signed [W-1:0] fill_buf [N_FEAT];
  logic                s_ready_q, s_ready_nxt;
  logic                frame_valid_q;
  logic                frame_err_q;
  logic [7:0]          err_cnt_q;

  logic beat_acc;
  logic at_last;
  logic slot_free;
  logic fill_wr;
  logic err_nxt;
  logic load;

  assign beat_acc  = bus.s_valid && s_ready_q;
  assign at_last   = (idx == LAST_IDX);
  assign slot_free = !frame_valid_q || bus.frame_ready;

  assign bus.s_ready     = s_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_cnt     = err_cnt_q;

  // State register; s_ready is registered from the next state so it is low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      s_ready_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_ready_q <= s_ready_nxt;
    end
  end

  // Next-state: complete frame -> FULL, overrun -> DISCARD, FULL leaves once the slot frees.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (beat_acc && at_last) state_nxt = bus.s_last ? FULL : DISCARD;
      FULL:    if (slot_free) state_nxt = FILL;
      DISCARD: if (beat_acc && bus.s_last) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Decoded controls: a malformed frame is s_last disagreeing with the final slot position.
  always_comb begin
    s_ready_nxt = (state_nxt != FULL);
    fill_wr     = beat_acc && (state == FILL);
    err_nxt     = fill_wr && (bus.s_last != at_last);
    load        = (state == FULL) && slot_free;
  end

  // Fill side: write slot idx, wrap to 0 at a frame boundary or overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      for (int i = 0; i < N_FEAT; i++) fill_buf[i] <= '0;
    end else if (fill_wr) begin
      fill_buf[idx] <= bus.s_feat;
      idx           <= (bus.s_last || at_last) ? '0 : idx + 1'b1;
    end
  end

  // Output slot: load on transfer, otherwise drop valid when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_q <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) bus.features[i] <= '0;
    end else if (load) begin
      frame_valid_q <= 1'b1;
      for (int i = 0; i < N_FEAT; i++) bus.features[i] <= fill_buf[i];
    end else if (bus.frame_ready) begin
      frame_valid_q <= 1'b0;
    end
  end

  // Error pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      frame_err_q <= err_nxt;
      if (err_nxt && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

`ifdef FRAME_SILENCE_FLAG_EN
  logic any_nz;
  logic frame_silent_q;
  assign bus.frame_silent = frame_silent_q;

  // Running OR of the frame being filled; restarts on slot 0 so no extra clear is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_nz <= 1'b0;
    end else if (fill_wr) begin
      any_nz <= (idx == '0) ? (|bus.s_feat) : (any_nz | (|bus.s_feat));
    end
  end

  // Silence flag travels with the frame it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_silent_q <= 1'b0;
    end else if (load) begin
      frame_silent_q <= !any_nz;
    end
  end
`endif

endmodule

// File: tb/tb_feature_frame_builder.sv
// Directed bench for feature_frame_builder: single/held frame, back-to-back, short, long,
// mid-frame reset with counter saturation, and the optional silence flag.
module tb_feature_frame_builder;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  feature_frame_builder_if #(.N_FEAT(26), .W(16)) bus ();

  feature_frame_builder #(.N_FEAT(26), .W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // Drive one beat from a negedge; returns on the negedge after the accepting edge.
  task automatic drive_beat(input logic signed [15:0] v, input logic l);
    int budget;
    bus.s_feat  = v;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    budget = 0;
    while (bus.s_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) begin
      tests++; fails++;
      $display("FAIL beat_timeout: s_ready=%b, required 1 within 200 cycles", bus.s_ready);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_feat = '0; bus.frame_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Sends values base+1 .. base+n with s_last on beat n.
  task automatic send_frame(input int base, input int n);
    for (int i = 1; i <= n; i++) drive_beat(16'(base + i), i == n);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_feat = '0; bus.frame_ready = 1'b0;
    rst_n = 1'b0;
    #13;
    tests++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    tests++; if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL rst_frame_valid: got %b want 0", bus.frame_valid); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL rst_frame_err: got %b want 0", bus.frame_err); end
    tests++; if (bus.err_cnt !== 8'd0) begin fails++; $display("FAIL rst_err_cnt: got %0d want 0", bus.err_cnt); end
    tests++; if (bus.features[0] !== 16'sd0 || bus.features[25] !== 16'sd0) begin
      fails++; $display("FAIL rst_features: got %0d/%0d want 0/0", bus.features[0], bus.features[25]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL rst_release_s_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_single();
    send_frame(0, 26);
    tests++; if (bus.frame_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      fails++; $display("FAIL single_e0: frame_valid=%b s_ready=%b want 0/0", bus.frame_valid, bus.s_ready);
    end
    @(negedge clk);
    tests++; if (bus.frame_valid !== 1'b1 || bus.s_ready !== 1'b1) begin
      fails++; $display("FAIL single_e1: frame_valid=%b s_ready=%b want 1/1", bus.frame_valid, bus.s_ready);
    end
    tests++; if (bus.features[0] !== 16'sd1 || bus.features[12] !== 16'sd13 || bus.features[25] !== 16'sd26) begin
      fails++; $display("FAIL single_data: got %0d/%0d/%0d want 1/13/26", bus.features[0], bus.features[12], bus.features[25]);
    end
    send_frame(100, 26);
    repeat (5) @(negedge clk);
    tests++; if (bus.s_ready !== 1'b0 || bus.frame_valid !== 1'b1) begin
      fails++; $display("FAIL hold_flags: s_ready=%b frame_valid=%b want 0/1", bus.s_ready, bus.frame_valid);
    end
    tests++; if (bus.features[0] !== 16'sd1 || bus.features[25] !== 16'sd26) begin
      fails++; $display("FAIL hold_data: got %0d/%0d want 1/26", bus.features[0], bus.features[25]);
    end
    bus.frame_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus.frame_valid !== 1'b1 || bus.features[0] !== 16'sd101 || bus.features[25] !== 16'sd126) begin
      fails++; $display("FAIL replace: valid=%b data=%0d/%0d want 1 101/126", bus.frame_valid, bus.features[0], bus.features[25]);
    end
    @(negedge clk);
    tests++; if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL consume: frame_valid=%b want 0", bus.frame_valid); end
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nfr;
    int cyc [2];
    bus.frame_ready = 1'b1;
    nfr = 0;
    fork
      begin
        for (int i = 1; i <= 26; i++) drive_beat(-16'sd5, i == 26);
        for (int i = 1; i <= 26; i++) drive_beat(16'sd7, i == 26);
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
      end
      begin
        for (int c = 0; c < 80; c++) begin
          @(negedge clk);
          if (bus.frame_valid === 1'b1) begin
            logic signed [15:0] exp_v;
            int bad;
            exp_v = (nfr == 0) ? -16'sd5 : 16'sd7;
            bad = 0;
            for (int k = 0; k < 26; k++) if (bus.features[k] !== exp_v) bad++;
            tests++; if (bad != 0) begin
              fails++; $display("FAIL b2b_frame%0d: %0d elements differ, features[0]=%0d want %0d", nfr, bad, bus.features[0], exp_v);
            end
            if (nfr < 2) cyc[nfr] = c;
            nfr++;
          end
        end
      end
    join
    tests++; if (nfr != 2) begin fails++; $display("FAIL b2b_count: got %0d frames want 2", nfr); end
    tests++; if (nfr >= 2 && (cyc[1] - cyc[0]) != 27) begin
      fails++; $display("FAIL b2b_period: got %0d cycles want 27", cyc[1] - cyc[0]);
    end
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_short();
    do_reset();
    send_frame(0, 10);
    tests++; if (bus.frame_err !== 1'b1 || bus.err_cnt !== 8'd1) begin
      fails++; $display("FAIL short_err: frame_err=%b err_cnt=%0d want 1/1", bus.frame_err, bus.err_cnt);
    end
    @(negedge clk);
    tests++; if (bus.frame_err !== 1'b0 || bus.frame_valid !== 1'b0) begin
      fails++; $display("FAIL short_after: frame_err=%b frame_valid=%b want 0/0", bus.frame_err, bus.frame_valid);
    end
    send_frame(200, 26);
    @(negedge clk);
    tests++; if (bus.frame_valid !== 1'b1 || bus.features[0] !== 16'sd201 || bus.features[25] !== 16'sd226) begin
      fails++; $display("FAIL short_next: valid=%b data=%0d/%0d want 1 201/226", bus.frame_valid, bus.features[0], bus.features[25]);
    end
  endtask

  task automatic test_long();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 1; i <= 30; i++) begin
      drive_beat(16'(300 + i), i == 30);
      if (bus.frame_err === 1'b1) errs++;
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    @(negedge clk);
    if (bus.frame_err === 1'b1) errs++;
    tests++; if (errs != 1) begin fails++; $display("FAIL long_pulses: got %0d want 1", errs); end
    tests++; if (bus.err_cnt !== 8'd1 || bus.frame_valid !== 1'b0) begin
      fails++; $display("FAIL long_state: err_cnt=%0d frame_valid=%b want 1/0", bus.err_cnt, bus.frame_valid);
    end
    send_frame(400, 26);
    @(negedge clk);
    tests++; if (bus.frame_valid !== 1'b1 || bus.features[0] !== 16'sd401 || bus.features[25] !== 16'sd426) begin
      fails++; $display("FAIL long_align: valid=%b data=%0d/%0d want 1 401/426", bus.frame_valid, bus.features[0], bus.features[25]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(0, 26);
    @(negedge clk);
    for (int i = 1; i <= 13; i++) drive_beat(16'(500 + i), 1'b0);
    bus.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.frame_valid !== 1'b0 || bus.s_ready !== 1'b0 || bus.features[0] !== 16'sd0) begin
      fails++; $display("FAIL midrst: valid=%b s_ready=%b f0=%0d want 0/0/0", bus.frame_valid, bus.s_ready, bus.features[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(600, 26);
    @(negedge clk);
    tests++; if (bus.features[0] !== 16'sd601 || bus.features[25] !== 16'sd626) begin
      fails++; $display("FAIL midrst_align: got %0d/%0d want 601/626", bus.features[0], bus.features[25]);
    end
    for (int n = 1; n <= 300; n++) begin
      drive_beat(16'(n), 1'b1);
      if (n == 100) begin
        tests++; if (bus.err_cnt !== 8'd100) begin fails++; $display("FAIL cnt100: got %0d want 100", bus.err_cnt); end
      end
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    tests++; if (bus.err_cnt !== 8'd255) begin fails++; $display("FAIL cnt_sat: got %0d want 255", bus.err_cnt); end
  endtask

`ifdef FRAME_SILENCE_FLAG_EN
  task automatic test_silence();
    do_reset();
    for (int i = 1; i <= 26; i++) drive_beat(16'sd0, i == 26);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    @(negedge clk);
    tests++; if (bus.frame_silent !== 1'b1) begin fails++; $display("FAIL silent_zero: got %b want 1", bus.frame_silent); end
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
    for (int i = 1; i <= 26; i++) drive_beat((i == 26) ? -16'sd1 : 16'sd0, i == 26);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    @(negedge clk);
    tests++; if (bus.frame_silent !== 1'b0 || bus.features[25] !== -16'sd1) begin
      fails++; $display("FAIL silent_last: silent=%b f25=%0d want 0/-1", bus.frame_silent, bus.features[25]);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_short();
    test_long();
    test_reset_mid();
`ifdef FRAME_SILENCE_FLAG_EN
    test_silence();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
